// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and widths for the two-requester ALU sharing controller.
package alu_ctrl_pkg;

  localparam int OPND_W = 3;
  localparam int RES_W  = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one external 3-bit ALU between two requesters, one operation in flight.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int ALU_SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [1:0]          req0_op,
  input  logic [OPND_W-1:0]   req0_a,
  input  logic [OPND_W-1:0]   req0_b,
  input  logic                req0_cin,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [1:0]          req1_op,
  input  logic [OPND_W-1:0]   req1_a,
  input  logic [OPND_W-1:0]   req1_b,
  input  logic                req1_cin,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic [RES_W-1:0]    rsp0_data,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [RES_W-1:0]    rsp1_data,
  output logic [1:0]          alu_mode,
  output logic [OPND_W-1:0]   alu_a,
  output logic [OPND_W-1:0]   alu_b,
  output logic                alu_cin,
  input  logic [RES_W-1:0]    alu_result,
  output state_t              fsm_state
);

  localparam logic [3:0] SETTLE_M1 = 4'(ALU_SETTLE - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic               owner;
  logic               last_grant;
  logic [RES_W-1:0]   result;
  logic [1:0]         grant;

  // Handshakes: a transfer happens in the cycle where valid && ready are both 1.
  // Requesters hold valid (and payload) until ready; ready is only raised in IDLE
  // for the arbitration winner, so it never appears without its own valid.
  rr_arb2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .en         (state == IDLE),
    .grant      (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  assign rsp0_valid = (state == RESP) && !owner;
  assign rsp1_valid = (state == RESP) &&  owner;
  assign rsp0_data  = result;
  assign rsp1_data  = result;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      alu_mode   <= 2'b00;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[0]) begin
            alu_mode <= req0_op;
            alu_a    <= req0_a;
            alu_b    <= req0_b;
            alu_cin  <= req0_cin;
            owner    <= 1'b0;
            cnt      <= SETTLE_M1;
            state    <= EXEC;
          end else if (grant[1]) begin
            alu_mode <= req1_op;
            alu_a    <= req1_a;
            alu_b    <= req1_b;
            alu_cin  <= req1_cin;
            owner    <= 1'b1;
            cnt      <= SETTLE_M1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs stay frozen; sample only once the settle window has elapsed.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            result <= alu_result;
            state  <= RESP;
          end
        end
        RESP: begin
          if (owner ? rsp1_ready : rsp0_ready) begin
            last_grant <= owner;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: one instance with settle 1, one with settle 4.
module tb_alu_share_ctrl;
  import alu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A (ALU_SETTLE=1)
  logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [1:0] req0_op = 0, req1_op = 0;
  logic [2:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_cin = 0, req1_cin = 0;
  logic       rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic [3:0] rsp0_data, rsp1_data, alu_result;
  logic [1:0] alu_mode;
  logic [2:0] alu_a, alu_b;
  logic       alu_cin;
  state_t     fsm_state;

  // Instance B (ALU_SETTLE=4), ALU model with 3-cycle output delay
  logic       s_req0_valid = 0, s_req1_valid = 0, s_req0_ready, s_req1_ready;
  logic [1:0] s_req0_op = 0, s_req1_op = 0;
  logic [2:0] s_req0_a = 0, s_req0_b = 0, s_req1_a = 0, s_req1_b = 0;
  logic       s_req0_cin = 0, s_req1_cin = 0;
  logic       s_rsp0_valid, s_rsp1_valid, s_rsp0_ready = 0, s_rsp1_ready = 0;
  logic [3:0] s_rsp0_data, s_rsp1_data, s_alu_result;
  logic [1:0] s_alu_mode;
  logic [2:0] s_alu_a, s_alu_b;
  logic       s_alu_cin;
  state_t     s_fsm_state;
  logic [3:0] d1 = 0, d2 = 0, d3 = 0;

  function automatic logic [3:0] alu_f(input logic [1:0] m, input logic [2:0] a, input logic [2:0] b,
                                       input logic cin);
    case (m)
      2'b00:   return {1'b0, a} + {1'b0, b} + {3'b000, cin};
      2'b01:   return {1'b0, a} + {1'b0, ~b} + 4'd1;
      2'b10:   return {1'b0, a ^ b};
      default: return {1'b0, a & b};
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_mode, alu_a, alu_b, alu_cin);

  always @(posedge clk) begin
    d1 <= alu_f(s_alu_mode, s_alu_a, s_alu_b, s_alu_cin);
    d2 <= d1;
    d3 <= d2;
  end
  assign s_alu_result = d3;

  alu_share_ctrl #(.ALU_SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .fsm_state(fsm_state)
  );

  alu_share_ctrl #(.ALU_SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(s_req0_op),
    .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_cin(s_req0_cin),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_op(s_req1_op),
    .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_cin(s_req1_cin),
    .rsp0_valid(s_rsp0_valid), .rsp0_ready(s_rsp0_ready), .rsp0_data(s_rsp0_data),
    .rsp1_valid(s_rsp1_valid), .rsp1_ready(s_rsp1_ready), .rsp1_data(s_rsp1_data),
    .alu_mode(s_alu_mode), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_cin(s_alu_cin),
    .alu_result(s_alu_result), .fsm_state(s_fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation on instance A with responses accepted at once.
  // lat counts cycles from accept to first rsp_valid (-1 if never accepted).
  task automatic run_op(input logic n, input logic [1:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic cin, output logic [3:0] data, output int lat, output int other_seen);
    int guard;
    rsp0_ready = 1; rsp1_ready = 1;
    other_seen = 0; data = '0; lat = -1;
    if (!n) begin
      req0_op = op; req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1;
    end
    #1;
    guard = 0;
    while (((n ? req1_ready : req0_ready) !== 1'b1) && guard < 20) begin
      tick(); guard++;
    end
    if (guard >= 20) begin
      req0_valid = 0; req1_valid = 0;
      return;
    end
    tick();
    req0_valid = 0; req1_valid = 0;
    lat = 1;
    while (((n ? rsp1_valid : rsp0_valid) !== 1'b1) && lat < 30) begin
      if (n ? rsp0_valid : rsp1_valid) other_seen++;
      tick(); lat++;
    end
    data = n ? rsp1_data : rsp0_data;
    if (n ? rsp0_valid : rsp1_valid) other_seen++;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 0;
    tick(); tick();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", req1_ready, req0_ready); end
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", rsp1_valid, rsp0_valid); end
    checks++; if ({alu_mode, alu_a, alu_b, alu_cin} !== 9'd0) begin
      errors++; $display("FAIL reset_alu: got %h expected 0", {alu_mode, alu_a, alu_b, alu_cin}); end
    checks++; if (fsm_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", fsm_state, IDLE); end
    rst_n = 1;
    tick();
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL idle_no_valid_ready: got %b%b expected 00", req1_ready, req0_ready); end
  endtask

  task automatic test_single_add();
    logic [3:0] d; int lat; int oth;
    run_op(1'b0, OP_ADD, 3'd5, 3'd3, 1'b0, d, lat, oth);
    checks++; if (d !== 4'b1000) begin errors++; $display("FAIL add_data: got %b expected 1000", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d expected 2", lat); end
    checks++; if (oth !== 0) begin errors++; $display("FAIL add_rsp1_valid: got %0d expected 0", oth); end
    checks++; if ({alu_mode, alu_a, alu_b} !== {2'b00, 3'd5, 3'd3}) begin
      errors++; $display("FAIL add_alu_hold: got %h expected %h", {alu_mode, alu_a, alu_b}, {2'b00, 3'd5, 3'd3}); end
  endtask

  task automatic test_ops_req1();
    logic [1:0] ops [5] = '{OP_SUB, OP_XOR, OP_AND, OP_SUB, OP_SUB};
    logic [2:0] as  [5] = '{3'd5, 3'd5, 3'd5, 3'd2, 3'd5};
    logic [2:0] bs  [5] = '{3'd3, 3'd3, 3'd3, 3'd5, 3'd3};
    logic       cs  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] ex  [5] = '{4'b1010, 4'b0110, 4'b0001, 4'b0101, 4'b1010};
    logic [3:0] d; int lat; int oth;
    for (int i = 0; i < 5; i++) begin
      run_op(1'b1, ops[i], as[i], bs[i], cs[i], d, lat, oth);
      checks++; if (d !== ex[i]) begin
        errors++; $display("FAIL op%0d_data: got %b expected %b", i, d, ex[i]); end
      checks++; if (lat !== 2 || oth !== 0) begin
        errors++; $display("FAIL op%0d_timing: got lat=%0d rsp0=%0d expected lat=2 rsp0=0", i, lat, oth); end
    end
  endtask

  task automatic test_contention();
    int grants[$];
    rst_n = 0;
    req0_op = OP_ADD; req0_a = 3'd1; req0_b = 3'd2; req0_cin = 1;
    req1_op = OP_XOR; req1_a = 3'd7; req1_b = 3'd2; req1_cin = 0;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    tick(); tick();
    rst_n = 1;
    #1;
    for (int c = 0; c < 12; c++) begin
      checks++; if (req0_ready && req1_ready) begin
        errors++; $display("FAIL cont_both_ready: cycle %0d got 11 expected one-hot", c); end
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
      if (rsp0_valid) begin
        checks++; if (rsp0_data !== 4'b0100) begin
          errors++; $display("FAIL cont_rsp0_data: got %b expected 0100", rsp0_data); end
      end
      if (rsp1_valid) begin
        checks++; if (rsp1_data !== 4'b0101) begin
          errors++; $display("FAIL cont_rsp1_data: got %b expected 0101", rsp1_data); end
      end
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    repeat (4) tick();
    checks++; if (grants.size() !== 4) begin
      errors++; $display("FAIL cont_grant_count: got %0d expected 4", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      checks++; if (grants[i] !== (i % 2)) begin
        errors++; $display("FAIL cont_grant_order: grant %0d got %0d expected %0d", i, grants[i], i % 2); end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    rsp0_ready = 0; rsp1_ready = 1;
    req0_op = OP_ADD; req0_a = 3'd5; req0_b = 3'd3; req0_cin = 0; req0_valid = 1;
    #1;
    guard = 0;
    while (req0_ready !== 1'b1 && guard < 20) begin tick(); guard++; end
    tick();
    req0_valid = 0;
    req1_op = OP_AND; req1_a = 3'd5; req1_b = 3'd3; req1_cin = 0; req1_valid = 1;
    #1;
    guard = 0;
    while (rsp0_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++; if (guard >= 20) begin errors++; $display("FAIL bp_rsp_timeout: got no rsp0_valid expected one"); end
    for (int c = 0; c < 5; c++) begin
      checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 4'b1000) begin
        errors++; $display("FAIL bp_hold: cycle %0d got v=%b d=%b expected v=1 d=1000", c, rsp0_valid, rsp0_data); end
      checks++; if (req1_ready !== 1'b0 || rsp1_valid !== 1'b0) begin
        errors++; $display("FAIL bp_block: cycle %0d got ready1=%b rsp1v=%b expected 0 0", c, req1_ready, rsp1_valid); end
      tick();
    end
    rsp0_ready = 1;
    tick();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_accept: got %b expected 1", req1_ready); end
    tick();
    req1_valid = 0;
    guard = 0;
    while (rsp1_valid !== 1'b1 && guard < 20) begin tick(); guard++; end
    checks++; if (rsp1_data !== 4'b0001 || rsp1_valid !== 1'b1) begin
      errors++; $display("FAIL bp_rsp1_data: got v=%b d=%b expected v=1 d=0001", rsp1_valid, rsp1_data); end
    tick();
  endtask

  task automatic test_settle();
    logic [1:0] ops [2] = '{OP_ADD, OP_XOR};
    logic [3:0] ex  [2] = '{4'b1110, 4'b0001};
    int lat;
    s_rsp0_ready = 1;
    for (int i = 0; i < 2; i++) begin
      s_req0_op = ops[i]; s_req0_a = 3'd6; s_req0_b = 3'd7; s_req0_cin = 1; s_req0_valid = 1;
      #1;
      checks++; if (s_req0_ready !== 1'b1) begin
        errors++; $display("FAIL settle%0d_ready: got %b expected 1", i, s_req0_ready); end
      tick();
      s_req0_valid = 0;
      lat = 1;
      while (s_rsp0_valid !== 1'b1 && lat < 30) begin tick(); lat++; end
      checks++; if (lat !== 5) begin errors++; $display("FAIL settle%0d_latency: got %0d expected 5", i, lat); end
      checks++; if (s_rsp0_data !== ex[i]) begin
        errors++; $display("FAIL settle%0d_data: got %b expected %b", i, s_rsp0_data, ex[i]); end
      tick();
    end
  endtask

  task automatic test_reset_mid_op();
    int stale;
    s_rsp0_ready = 1;
    s_req0_op = OP_ADD; s_req0_a = 3'd7; s_req0_b = 3'd7; s_req0_cin = 1; s_req0_valid = 1;
    #1;
    tick();
    s_req0_valid = 0;
    tick();
    checks++; if (s_fsm_state !== EXEC) begin
      errors++; $display("FAIL rst_mid_in_exec: got %0d expected %0d", s_fsm_state, EXEC); end
    rst_n = 0;
    #1;
    checks++; if ({s_alu_mode, s_alu_a, s_alu_b, s_alu_cin} !== 9'd0 || s_fsm_state !== IDLE) begin
      errors++; $display("FAIL rst_mid_async_b: got alu=%h st=%0d expected 0 0",
                         {s_alu_mode, s_alu_a, s_alu_b, s_alu_cin}, s_fsm_state); end
    checks++; if ({alu_mode, alu_a, alu_b, alu_cin} !== 9'd0) begin
      errors++; $display("FAIL rst_mid_async_a: got alu=%h expected 0", {alu_mode, alu_a, alu_b, alu_cin}); end
    checks++; if ({s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_handshake: got %b expected 0000",
                         {s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid}); end
    tick(); tick();
    rst_n = 1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (s_rsp0_valid || s_rsp1_valid || rsp0_valid || rsp1_valid) stale++;
      tick();
    end
    checks++; if (stale !== 0) begin errors++; $display("FAIL rst_mid_stale_rsp: got %0d expected 0", stale); end
    req0_valid = 1; req1_valid = 1;
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL rst_first_tie: got %b%b expected 01", req1_ready, req0_ready); end
    req0_valid = 0; req1_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_ops_req1();
    test_contention();
    test_backpressure();
    test_settle();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
